ps2_key_writer: RTL
===================

// Module: ps2_key_writer
// PURPOSE
//  Upstream feeder of the keyboard character RAM. Receives raw PS/2 frames,
//  validates them, and decodes make/break/extended sequences. Emits one write
//  strobe per new key press, carrying the scancode and the current cursor cell
//  address. Also manages the text cursor: advance, wrap, backspace, enter.
// PARAMETERS
//  ROW_LEN   32     cells per text row; power of two; used by Enter alignment
//  CELLS     256    total cursor cells; cursor wraps CELLS-1 -> 0
//  TIMEOUT   50000  clk cycles without a ps2_clk fall before a partial frame is dropped
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous active-high reset
//  ps2_clk    in   1  raw PS/2 clock (asynchronous)
//  ps2_data   in   1  raw PS/2 data (asynchronous)
//  we         out  1  one-cycle write strobe to char RAM
//  inaddr     out  8  cursor cell written when we=1
//  din        out  8  scancode written (8'h00 = blank cell)
//  key_down   out  1  high while a non-extended make code is held
//  frame_err  out  1  one-cycle pulse: bad start, stop or parity
// BEHAVIOUR
//  Reset: we=0, inaddr=0, din=0, key_down=0, frame_err=0, cursor=0, FSM=IDLE,
//   last_code=0. All reset values are applied on the clk edge while rst=1.
//   A frame in progress at reset is discarded.
//  Sync: ps2_clk and ps2_data pass through a 3-flop synchronizer.
//   A fall is detected as sync[2:1]==2'b10. Data is sampled on the same
//   cycle the fall is detected.
//  Frame: 11 bits, LSB first: start(0), d[7:0], odd parity, stop(1).
//   A bit counter of 0..10 captures the frame.
//   On bit 10: frame valid if start=0, stop=1 and ^{d,par}=1.
//   Invalid frame: frame_err pulses 1 cycle; the byte is dropped and the FSM
//   is unchanged.
//  Timeout: a counter clears on each fall. If it reaches TIMEOUT while the
//   bit count is nonzero, the bit count returns to 0 with no error pulse.
//  Decode FSM (advances on each valid byte):
//   IDLE:   F0 -> BREAK; E0 -> EXT; else -> MAKE action, stay IDLE.
//   BREAK:  any byte -> IDLE. If the byte equals last_code: key_down=0 and
//           last_code=0.
//   EXT:    F0 -> EXT_BRK; any other byte ignored -> IDLE.
//   EXT_BRK: any byte -> IDLE, ignored.
//  MAKE action for code c:
//   - c==last_code (typematic repeat): no write.
//   - c==8'h66 (Backspace): cursor=cursor-1 (0 wraps to CELLS-1); write din=00
//     at the new cursor.
//   - c==8'h5A (Enter): cursor = next multiple of ROW_LEN, modulo CELLS. No write.
//   - otherwise: write din=c at cursor, then cursor=cursor+1, wrapping at CELLS.
//   - In every case: last_code=c and key_down=1.
//  Write timing: we is asserted exactly one cycle, the cycle after the stop
//   bit is sampled. inaddr and din are valid in that cycle and held afterwards
//   until the next write. The cursor update is visible on inaddr only at the
//   next write.
//  Simultaneous events: a timeout and a fall in the same cycle resolve in
//   favour of the fall. rst overrides everything.
// TESTING
//  1. Reset, send 0x1C (odd par=0) -> one we pulse, inaddr=00, din=1C,
//     key_down=1.
//  2. Send 1C,1C,F0,1C,1C -> exactly two writes: din=1C at addr 00, then 01.
//     key_down=0 after the F0,1C pair.
//  3. Cursor=FF, send 0x32 then F0 32 -> write at FF; the next make (0x21)
//     writes at 00.
//  4. Cursor=00, send 0x66 -> write din=00 at addr FF. Cursor=05, send 0x5A,
//     then 0x1C -> write at 20.
//  5. Frame with a wrong parity bit -> frame_err pulses, no we. Frame with
//     stop=0 -> same result.
//  6. Send 4 bits, idle TIMEOUT+1 cycles, then send full 0x1C -> a single
//     correct write. Send E0 75 E0 F0 75 -> no write. Assert rst mid-frame ->
//     outputs return to reset values.

Source files
------------

// File: rtl/ps2_key_writer.sv
// ps2_key_writer: PS/2 receiver, scancode decoder and text cursor for the keyboard char RAM.
// Receives raw PS/2 frames, checks start/stop/odd parity, and decodes make, break and
// extended sequences. Each new key press produces one write strobe carrying the scancode
// and the cursor cell. Backspace blanks the previous cell, and Enter jumps to the next row.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   ps2_clk, ps2_data  raw asynchronous PS/2 lines
//   we                 one-cycle write strobe to the char RAM
//   inaddr, din        cell address and scancode for the write; held until the next write
//   key_down           high while a non-extended make code is held
//   frame_err          one-cycle pulse on a bad start, stop or parity bit
module ps2_key_writer #(
  parameter int unsigned ROW_LEN = 32,
  parameter int unsigned CELLS   = 256,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       we,
  output logic [7:0] inaddr,
  output logic [7:0] din,
  output logic       key_down,
  output logic       frame_err
);

  typedef enum logic [1:0] {StIdle, StBreak, StExt, StExtBrk} state_e;

  localparam int unsigned ToW      = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  LastCell = 8'(CELLS - 1);
  localparam logic [7:0]  RowMask  = 8'(ROW_LEN - 1);
  localparam logic [8:0]  CellsW   = 9'(CELLS);
  localparam logic [7:0]  CodeBrk  = 8'hF0;
  localparam logic [7:0]  CodeExt  = 8'hE0;
  localparam logic [7:0]  CodeBs   = 8'h66;
  localparam logic [7:0]  CodeEnt  = 8'h5A;

  state_e           state_q, state_d;
  logic [2:0]       clk_sync_q, data_sync_q;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       shift_q, shift_d;   // start, d[7:0], parity once ten bits are in
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]       cursor_q, cursor_d, last_code_q, last_code_d;
  logic [7:0]       inaddr_q, inaddr_d, din_q, din_d;
  logic             we_q, we_d, key_down_q, key_down_d, frame_err_q, frame_err_d;

  logic             fall, bit_in, byte_done, byte_valid;
  logic [7:0]       rx_byte, cursor_inc, cursor_dec, enter_tgt;
  logic [8:0]       enter_sum;

  assign fall       = (clk_sync_q[2:1] == 2'b10);
  assign bit_in     = data_sync_q[2];
  assign byte_done  = fall && (bit_cnt_q == 4'd10);
  // bit_in is the stop bit when byte_done is set
  assign byte_valid = byte_done && !shift_q[0] && bit_in && (^shift_q[9:1]);
  assign rx_byte    = shift_q[8:1];

  assign cursor_inc = (cursor_q == LastCell) ? 8'd0 : cursor_q + 8'd1;
  assign cursor_dec = (cursor_q == 8'd0) ? LastCell : cursor_q - 8'd1;
  // Strictly the next row start, so Enter on a row boundary still advances a full row
  assign enter_sum  = {1'b0, cursor_q | RowMask} + 9'd1;
  assign enter_tgt  = (enter_sum >= CellsW) ? 8'(enter_sum - CellsW) : enter_sum[7:0];

  // Receiver: bit counter, shift register, inter-bit timeout (a fall beats a timeout)
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_cnt_d  = to_cnt_q;
    if (fall) begin
      to_cnt_d  = '0;
      shift_d   = {bit_in, shift_q[9:1]};
      bit_cnt_d = (bit_cnt_q == 4'd10) ? 4'd0 : bit_cnt_q + 4'd1;
    end else begin
      if (to_cnt_q != ToW'(TIMEOUT)) to_cnt_d = to_cnt_q + ToW'(1);
      if ((to_cnt_q == ToW'(TIMEOUT)) && (bit_cnt_q != 4'd0)) bit_cnt_d = 4'd0;
    end
  end

  // Decode FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Decode FSM next state
  always_comb begin
    state_d = state_q;
    if (byte_valid) begin
      unique case (state_q)
        StIdle: begin
          if (rx_byte == CodeBrk)      state_d = StBreak;
          else if (rx_byte == CodeExt) state_d = StExt;
        end
        StBreak:  state_d = StIdle;
        StExt:    state_d = (rx_byte == CodeBrk) ? StExtBrk : StIdle;
        StExtBrk: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Decode actions: writes, cursor, held-key tracking
  always_comb begin
    we_d        = 1'b0;
    inaddr_d    = inaddr_q;
    din_d       = din_q;
    cursor_d    = cursor_q;
    last_code_d = last_code_q;
    key_down_d  = key_down_q;
    frame_err_d = byte_done && !byte_valid;
    if (byte_valid) begin
      unique case (state_q)
        StIdle: begin
          if ((rx_byte != CodeBrk) && (rx_byte != CodeExt)) begin
            // A repeat of the held code is typematic and writes nothing
            if (rx_byte != last_code_q) begin
              if (rx_byte == CodeBs) begin
                we_d     = 1'b1;
                inaddr_d = cursor_dec;
                din_d    = 8'h00;
                cursor_d = cursor_dec;
              end else if (rx_byte == CodeEnt) begin
                cursor_d = enter_tgt;
              end else begin
                we_d     = 1'b1;
                inaddr_d = cursor_q;
                din_d    = rx_byte;
                cursor_d = cursor_inc;
              end
            end
            last_code_d = rx_byte;
            key_down_d  = 1'b1;
          end
        end
        StBreak: begin
          if (rx_byte == last_code_q) begin
            key_down_d  = 1'b0;
            last_code_d = 8'h00;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 3'b111;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      cursor_q    <= 8'd0;
      last_code_q <= 8'd0;
      we_q        <= 1'b0;
      inaddr_q    <= 8'd0;
      din_q       <= 8'd0;
      key_down_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[1:0], ps2_data};
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      cursor_q    <= cursor_d;
      last_code_q <= last_code_d;
      we_q        <= we_d;
      inaddr_q    <= inaddr_d;
      din_q       <= din_d;
      key_down_q  <= key_down_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign we        = we_q;
  assign inaddr    = inaddr_q;
  assign din       = din_q;
  assign key_down  = key_down_q;
  assign frame_err = frame_err_q;

endmodule
